// File: rtl/instruction_memory_32bit.sv
// Word-addressed instruction memory with a default image restored on reset.
// Define IMEM_PROG_PORT_EN to enable the synchronous program write port.
module instruction_memory_32bit #(
  parameter int AWIDTH = 6,
  parameter int RWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  output logic [RWIDTH-1:0] read_data,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [RWIDTH-1:0] wr_data
);

  localparam int DEPTH = 2 ** AWIDTH;

  function automatic logic [RWIDTH-1:0] dflt_word(
    input logic [AWIDTH-1:0] a
  );
    logic [RWIDTH-1:0] w;
    w = '0;
    w[RWIDTH-1 -: 16] = 16'hA5A5;
    w[AWIDTH-1:0] = a;
    return w;
  endfunction

`ifdef IMEM_PROG_PORT_EN

  logic [RWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= dflt_word(AWIDTH'(i));
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign read_data = mem_q[addr];

`else

  // Pure ROM: the image is a function of the address.
  logic unused_ports;
  assign unused_ports = ^{clk, rst, wr_en, wr_addr, wr_data};

  assign read_data = dflt_word(addr);

`endif

endmodule

// File: tb/tb_instruction_memory_32bit.sv
// Bench for instruction_memory_32bit: directed cases plus random traffic
// checked against an array model of the memory.
module tb_instruction_memory_32bit;

  logic        clk;
  logic        rst;
  logic [5:0]  addr;
  logic [31:0] read_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  int checks;
  int passes;

  logic [31:0] model [64];

  instruction_memory_32bit dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .read_data (read_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IMEM_PROG_PORT_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 32'hA5A5_0000 + i;
  endtask

  task automatic step(input logic we, input logic [5:0] wa,
                      input logic [31:0] wd, input logic [5:0] ra,
                      input string tag);
    @(negedge clk);
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    addr = ra;
    #1 check({tag, "_pre"}, read_data, model[ra]);
    @(posedge clk);
    if (PROG && we && !rst) model[wa] = wd;
    #1 check({tag, "_post"}, read_data, model[ra]);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    addr = 6'd5;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    model_reset();
    #12 check("reset_val", read_data, 32'hA5A5_0005);

    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #20 check("sweep", read_data, 32'hA5A5_0000 + a);
    end
    check("sweep_top", read_data, 32'hA5A5_003F);

    step(1'b1, 6'd10, 32'hDEAD_BEEF, 6'd10, "wr10");
    step(1'b0, 6'd10, 32'h0, 6'd10, "rd10");
    check("wr10_val", read_data, PROG ? 32'hDEAD_BEEF : 32'hA5A5_000A);
    step(1'b0, 6'd0, 32'h0, 6'd11, "rd11");
    check("rd11_val", read_data, 32'hA5A5_000B);

    step(1'b1, 6'd3, 32'h1234_5678, 6'd3, "same3");
    check("same3_val", read_data, PROG ? 32'h1234_5678 : 32'hA5A5_0003);

    step(1'b1, 6'd7, 32'hCAFE_F00D, 6'd7, "wr7");
    @(negedge clk);
    wr_en = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1 check("rst_async7", read_data, 32'hA5A5_0007);
    step(1'b1, 6'd7, 32'h5555_AAAA, 6'd7, "wr_in_rst");
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    #1 check("rst_rel7", read_data, 32'hA5A5_0007);

    for (int k = 0; k < 4; k++)
      step(1'b1, 6'd0, 32'hFFFF_FFFF, 6'd0, "rom0");
    check("rom0_val", read_data, PROG ? 32'hFFFF_FFFF : 32'hA5A5_0000);

    for (int k = 0; k < 300; k++) begin
      logic [5:0] wa;
      logic [5:0] ra;
      wa = 6'($urandom_range(0, 63));
      ra = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 40) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1 check("rnd_rst", read_data, model[addr]);
        @(negedge clk);
        rst = 1'b0;
      end
      step(1'($urandom_range(0, 1)), wa, $urandom, ra, "rnd");
    end

    @(negedge clk);
    wr_en = 1'b0;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #2 check("final_scan", read_data, model[a]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_32bit.md
# instruction_memory_32bit

Word-addressed instruction memory for the 32-bit processor datapath: fetch stage drives a 6-bit word address and receives the 32-bit instruction combinationally. Contents come from a fixed default image restored on reset. An optional synchronous program port overwrites words for loading test programs. Sits between the PC register and the instruction decoder.

## Interface
- AWIDTH, default 6: word-address width; depth = 2**AWIDTH words (64).
- RWIDTH, default 32: instruction word width in bits.

Ports. One clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock for program writes.
- rst  input  1  asynchronous, active-high; restores the default image.
- addr  input  AWIDTH  fetch word address, not a byte address.
- read_data  output  RWIDTH  instruction at addr, combinational.
- wr_en  input  1  program-port write enable, active-high.
- wr_addr  input  AWIDTH  program-port word address.
- wr_data  input  RWIDTH  program-port write data.

## Operation
- Storage: array of 2**AWIDTH words, RWIDTH bits each.
- Default image, restored while rst=1: word i = {16'hA5A5, (RWIDTH-16-AWIDTH)'b0, i[AWIDTH-1:0]}.
  - With defaults: word 0 = 32'hA5A5_0000, word 5 = 32'hA5A5_0005, word 63 = 32'hA5A5_003F.
- Read path:
  - read_data = mem[addr] at all times, including during reset (shows the default image).
  - No read enable.
  - Every addr value is in range; no wrap or out-of-range case.
- Write path (only when IMEM_PROG_PORT_EN is defined):
  - On rising clk with rst=0 and wr_en=1: mem[wr_addr] <= wr_data.
  - wr_en=0: memory unchanged.
- Read/write same address:
  - Before the edge, read_data shows the old word.
  - After the edge, read_data shows wr_data.
- Reset dominance:
  - rst asserted mid-operation overrides any write in the same cycle.
  - All words return to the default image immediately, without waiting for a clock.
- read_data has no state of its own; it always reflects the array.

## Timing
- Read latency: zero cycles, combinational from addr and array contents. Must settle within 20 ns of an addr change.
- Write latency: one clock edge. The written word is visible on read_data in the same cycle after the edge when addr == wr_addr.
- Reset:
  - Asserting rst forces the default image asynchronously.
  - Deasserting rst takes effect on the next rising clk.
  - Reset value of read_data = default word at the current addr.
- No handshake; fetch may change addr every cycle.

## Configuration
- Macro IMEM_PROG_PORT_EN.
- Defined: the program port writes as described above.
- Undefined:
  - The block is a pure ROM holding the default image.
  - wr_en, wr_addr and wr_data stay in the port list but are ignored.
  - No write logic is synthesized.

## Test plan
- Reset sweep: pulse rst; sweep addr 0..63 with 20 ns steps -> read_data = 32'hA5A5_0000 + addr at every step; addr=63 gives 32'hA5A5_003F.
- Program write (macro defined): wr_en=1, wr_addr=10, wr_data=32'hDEAD_BEEF for one edge; then addr=10 -> 32'hDEAD_BEEF, and addr=11 -> 32'hA5A5_000B.
- Same-address visibility: addr=3 held; write 32'h1234_5678 to word 3 -> read_data is 32'hA5A5_0003 before the edge and 32'h1234_5678 after it.
- Reset mid-operation: write 32'hCAFE_F00D to word 7; assert rst between edges -> read_data at addr=7 returns to 32'hA5A5_0007 immediately. A write attempted while rst=1 is ignored.
- ROM build (macro undefined): wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF for several edges -> addr=0 still reads 32'hA5A5_0000.
